// File: rtl/serial_nibble_rx.sv
// rtl/serial_nibble_rx.sv - framed serial-to-nibble deserializer with nibble FIFO (optional SERIAL_NIBBLE_RX_PARITY_EN)
module serial_nibble_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sin_valid,
    input  logic                          sin_start,
    input  logic                          sin_bit,
    output logic [3:0]                    nib_data,
    output logic                          nib_valid,
    input  logic                          nib_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    output logic                          frame_err,
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    output logic                          par_err,
`endif
    input  logic                          clr_flags
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t       state;
    logic [2:0]   cnt;
    logic [3:0]   sr;
    logic [3:0]   sr_next;
    logic [3:0]   sr_first;
    logic         last_bit;
    logic         push_req;
    logic [3:0]   push_data;
    logic         par_bad;

    logic [3:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]  count;
    logic         full;
    logic         pop;
    logic         push_ok;
    logic         ovf_set;

    // Next shift-register value and frame-completion decode for the current serial bit
    always_comb begin
        sr_next   = MSB_FIRST ? {sr[2:0], sin_bit} : {sin_bit, sr[3:1]};
        sr_first  = MSB_FIRST ? {3'b000, sin_bit} : {sin_bit, 3'b000};
        last_bit  = (state == SHIFT) && sin_valid && !sin_start
                    && (cnt == 3'(FRAME_LEN - 1));
        par_bad   = 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        // The final bit is the even-parity bit; the nibble is already complete in sr.
        push_data = sr;
        par_bad   = last_bit && ((^sr) ^ sin_bit);
        push_req  = last_bit && !par_bad;
`else
        // The final bit is a data bit, so the pushed nibble includes it.
        push_data = sr_next;
        push_req  = last_bit;
`endif
    end

    // Frame FSM: bit capture, restart on an unexpected start, error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            sr        <= 4'd0;
            frame_err <= 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            par_err   <= par_bad;
`endif
            if (sin_valid) begin
                if (state == IDLE) begin
                    if (sin_start) begin
                        sr    <= sr_first;
                        cnt   <= 3'd1;
                        state <= SHIFT;
                    end
                end else begin
                    if (sin_start) begin
                        // Partial frame is abandoned; this bit opens a fresh frame.
                        frame_err <= 1'b1;
                        sr        <= sr_first;
                        cnt       <= 3'd1;
                    end else if (last_bit) begin
                        cnt   <= 3'd0;
                        state <= IDLE;
                    end else begin
                        sr  <= sr_next;
                        cnt <= cnt + 3'd1;
                    end
                end
            end
        end
    end

    // FIFO handshake decode; a full FIFO still accepts a push when the head leaves this cycle
    always_comb begin
        full    = (count == (AW+1)'(FIFO_DEPTH));
        pop     = nib_valid && nib_ready;
        push_ok = push_req && (!full || pop);
        ovf_set = push_req && full && !pop;
    end

    // FIFO storage; contents need no reset because the read side is gated by occupancy
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end
        end
    end

    assign nib_valid = (count != '0);
    assign nib_data  = nib_valid ? mem[rptr] : 4'd0;
    assign level     = count;

endmodule

// File: tb/tb_serial_nibble_rx.sv
// tb/tb_serial_nibble_rx.sv - randomized and directed self-checking bench for serial_nibble_rx
module tb_serial_nibble_rx;

    localparam int DEPTH = 4;
    localparam bit MSBF  = 1'b1;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sin_start = 1'b0;
    logic       sin_bit = 1'b0;
    logic [3:0] nib_data;
    logic       nib_valid;
    logic       nib_ready = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic       ovf;
    logic       frame_err;
    logic       par_err;
    logic       clr_flags = 1'b0;

    int checks = 0;
    int fails  = 0;

    int fb[$];
    bit m_in;
    int m_q[$];
    bit m_ovf, m_fe, m_pe;

    serial_nibble_rx #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(MSBF)) dut (
        .clk(clk), .rst_n(rst_n),
        .sin_valid(sin_valid), .sin_start(sin_start), .sin_bit(sin_bit),
        .nib_data(nib_data), .nib_valid(nib_valid), .nib_ready(nib_ready),
        .level(level), .ovf(ovf), .frame_err(frame_err),
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        .par_err(par_err),
`endif
        .clr_flags(clr_flags)
    );

`ifndef SERIAL_NIBBLE_RX_PARITY_EN
    assign par_err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("nib_valid", int'(nib_valid), int'(m_q.size() > 0));
        chk("nib_data", int'(nib_data), (m_q.size() > 0) ? m_q[0] : 0);
        chk("level", int'(level), m_q.size());
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("frame_err", int'(frame_err), int'(m_fe));
        chk("par_err", int'(par_err), int'(m_pe));
    endtask

    task automatic model_clear();
        fb = {};
        m_in = 0;
        m_q = {};
        m_ovf = 0;
        m_fe = 0;
        m_pe = 0;
    endtask

    // Next model state from the current model state and the inputs about to be clocked
    task automatic model_update();
        bit push = 0;
        bit pop, full, set;
        int nib = 0;
        int sum = 0;
        m_fe = 0;
        m_pe = 0;
        if (sin_valid) begin
            if (sin_start) begin
                if (m_in) m_fe = 1;
                fb = {};
                fb.push_back(int'(sin_bit));
                m_in = 1;
            end else if (m_in) begin
                fb.push_back(int'(sin_bit));
                if (fb.size() == FL) begin
                    m_in = 0;
                    for (int i = 0; i < 4; i++)
                        nib += fb[i] << (MSBF ? (3 - i) : i);
                    foreach (fb[i]) sum += fb[i];
                    if (sum % 2 == 1 && FL == 5) m_pe = 1;
                    else push = 1;
                end
            end
        end
        pop  = (m_q.size() > 0) && nib_ready;
        full = (m_q.size() == DEPTH);
        set  = push && full && !pop;
        if (pop) void'(m_q.pop_front());
        if (push && !set) m_q.push_back(nib);
        if (set) m_ovf = 1;
        else if (clr_flags) m_ovf = 0;
    endtask

    task automatic step(input bit v, input bit s, input bit b, input bit r, input bit c);
        sin_valid = v; sin_start = s; sin_bit = b; nib_ready = r; clr_flags = c;
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sin_valid = 0; sin_start = 0; sin_bit = 0; nib_ready = 0; clr_flags = 0;
        model_clear();
        #1;
        compare();
        @(posedge clk);
        @(negedge clk);
        compare();
        rst_n = 1'b1;
    endtask

    task automatic send_nib(input int n, input bit rm, input bit rl);
        int bits[$];
        int p = 0;
        for (int i = 0; i < 4; i++) begin
            bits.push_back(MSBF ? ((n >> (3 - i)) & 1) : ((n >> i) & 1));
            p ^= bits[i];
        end
        if (FL == 5) bits.push_back(p);
        for (int i = 0; i < FL; i++)
            step(1, i == 0, bits[i][0], (i == FL - 1) ? rl : rm, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && m_q.size() > 0; i++) step(0, 0, 0, 1, 0);
        chk("drain_empty", int'(level), 0);
    endtask

    initial begin
        model_clear();
        #2;
        compare();
        chk("reset_level_lit", int'(level), 0);
        chk("reset_valid_lit", int'(nib_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic capture: nibble visible for exactly one cycle with ready high
        step(1, 1, 1, 1, 0); step(1, 0, 0, 1, 0); step(1, 0, 1, 1, 0); step(1, 0, 0, 1, 0);
        if (FL == 5) step(1, 0, 0, 1, 0);
        chk("basic_valid_lit", int'(nib_valid), 1);
        chk("basic_data_lit", int'(nib_data), 4'b1010);
        step(0, 0, 0, 1, 0);
        chk("basic_gone_lit", int'(nib_valid), 0);

        // Backpressure and overflow, then in-order drain and flag clear
        for (int k = 1; k <= 5; k++) send_nib(k, 0, 0);
        chk("ovf_level_lit", int'(level), 4);
        chk("ovf_set_lit", int'(ovf), 1);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_order_lit", int'(nib_data), k);
            step(0, 0, 0, 1, 0);
        end
        chk("ovf_empty_lit", int'(level), 0);
        step(0, 0, 0, 0, 1);
        chk("ovf_clr_lit", int'(ovf), 0);

        // Framing error: aborted frame then a clean 0101
        step(1, 1, 1, 0, 0); step(1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("ferr_pulse_lit", int'(frame_err), 1);
        step(1, 0, 1, 0, 0);
        chk("ferr_once_lit", int'(frame_err), 0);
        step(1, 0, 0, 0, 0); step(1, 0, 1, 0, 0);
        if (FL == 5) step(1, 0, 0, 0, 0);
        chk("ferr_level_lit", int'(level), 1);
        chk("ferr_data_lit", int'(nib_data), 4'b0101);
        drain();

        // Idle noise and a gapped 1111 frame
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
        chk("noise_level_lit", int'(level), 0);
        for (int i = 0; i < FL; i++) begin
            step(1, i == 0, 1'b1, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        chk("gap_data_lit", int'(nib_data), 4'b1111);
        drain();

        // Full FIFO with a pop in the cycle the fifth nibble completes
        for (int k = 6; k <= 9; k++) send_nib(k, 0, 0);
        send_nib(10, 0, 1);
        chk("fullpop_level_lit", int'(level), 4);
        chk("fullpop_ovf_lit", int'(ovf), 0);
        chk("fullpop_head_lit", int'(nib_data), 7);
        drain();

        // Reset during a half-received frame with data queued
        send_nib(3, 0, 0);
        step(1, 1, 1, 0, 0); step(1, 0, 1, 0, 0);
        do_reset();
        chk("rst_level_lit", int'(level), 0);
        send_nib(0, 0, 0);
        chk("rst_next_valid_lit", int'(nib_valid), 1);
        chk("rst_next_data_lit", int'(nib_data), 0);
        drain();

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        step(1, 1, 1, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 1, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("par_good_data_lit", int'(nib_data), 4'b1010);
        chk("par_good_err_lit", int'(par_err), 0);
        step(1, 1, 1, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 1, 0, 0); step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("par_bad_pulse_lit", int'(par_err), 1);
        chk("par_bad_level_lit", int'(level), 1);
        chk("par_bad_ovf_lit", int'(ovf), 0);
        drain();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 15,
                     1'($urandom_range(0, 1)), $urandom_range(0, 99) < 40,
                     $urandom_range(0, 99) < 5);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
